// File: rtl/sumatoria_pkg.sv
// Shared width helpers and majority threshold for the oversampled-bit
// summation pipeline.
package sumatoria_pkg;

  function automatic int cnt_w(input int osf);
    return $clog2(osf) + 1;
  endfunction

  function automatic int sum_w(input int samples, input int osf);
    return $clog2(samples * osf) + 1;
  endfunction

  function automatic int acc_w(input int samples, input int osf, input int words);
    return $clog2(samples * osf * words) + 1;
  endfunction

  // A slice votes 1 only when its count strictly exceeds this; a tie votes 0.
  function automatic int maj_thr(input int osf);
    return osf / 2;
  endfunction

endpackage

// File: rtl/sumatoria_acumulada_popcount_slice.sv
// Combinational ones-count of one OSF-bit oversampled slice.
module popcount_slice
  import sumatoria_pkg::*;
#(
  parameter int OSF = 8
) (
  input  logic [OSF-1:0]          bits_i,
  output logic [cnt_w(OSF)-1:0]   cnt_o
);

  localparam int CNT_W = cnt_w(OSF);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < OSF; i++) cnt_o = cnt_o + CNT_W'(bits_i[i]);
  end

endmodule

// File: rtl/sumatoria_acumulada.sv
// Two-stage oversampled-bit summation: per-slice popcount, word total with
// majority decisions, and a WORDS-long accumulation period.
module sumatoria_acumulada
  import sumatoria_pkg::*;
#(
  parameter int SAMPLES = 2,
  parameter int OSF     = 8,
  parameter int WORDS   = 4
) (
  input  logic                                   Clk,
  input  logic                                   Rst,
  input  logic                                   Enable,
  input  logic                                   Valid_in,
  input  logic [SAMPLES*OSF-1:0]                 Input,
  input  logic                                   Clear,
  output logic [sum_w(SAMPLES, OSF)-1:0]         Output,
  output logic [SAMPLES-1:0]                     Decision,
  output logic                                   Valid_out,
  output logic [acc_w(SAMPLES, OSF, WORDS)-1:0]  Acc,
  output logic                                   Acc_valid
);

  localparam int CNT_W  = cnt_w(OSF);
  localparam int SUM_W  = sum_w(SAMPLES, OSF);
  localparam int ACC_W  = acc_w(SAMPLES, OSF, WORDS);
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int THR    = maj_thr(OSF);

  logic [SAMPLES-1:0][CNT_W-1:0] cnt_raw, cnt_d, cnt_q;
  logic                          v1_d, v1_q;
  logic [SUM_W-1:0]              sum, out_d, out_q;
  logic [SAMPLES-1:0]            dec_now, dec_d, dec_q;
  logic                          vout_d, vout_q;
  logic [ACC_W-1:0]              run_base, run_d, run_q, acc_d, acc_q;
  logic [WCNT_W-1:0]             wcnt_base, wcnt_d, wcnt_q;
  logic                          accv_d, accv_q;

  for (genvar g = 0; g < SAMPLES; g++) begin : g_slice
    popcount_slice #(.OSF(OSF)) u_pc (
      .bits_i (Input[g*OSF +: OSF]),
      .cnt_o  (cnt_raw[g])
    );
  end

  always_comb begin
    v1_d  = Enable & Valid_in;
    cnt_d = v1_d ? cnt_raw : cnt_q;
  end

  always_comb begin
    sum     = '0;
    dec_now = '0;
    for (int k = 0; k < SAMPLES; k++) begin
      sum        = sum + SUM_W'(cnt_q[k]);
      dec_now[k] = cnt_q[k] > CNT_W'(THR);
    end
    out_d  = v1_q ? sum : out_q;
    dec_d  = v1_q ? dec_now : dec_q;
    vout_d = v1_q;
  end

  // Clear empties the period first; a word arriving alongside it then opens
  // the new period exactly like any other word (closing it when WORDS == 1).
  always_comb begin
    run_base  = Clear ? '0 : run_q;
    wcnt_base = Clear ? '0 : wcnt_q;
    run_d     = run_base;
    wcnt_d    = wcnt_base;
    acc_d     = acc_q;
    accv_d    = 1'b0;
    if (v1_q) begin
      if (wcnt_base == WCNT_W'(WORDS - 1)) begin
        acc_d  = run_base + ACC_W'(sum);
        accv_d = 1'b1;
        run_d  = '0;
        wcnt_d = '0;
      end else begin
        run_d  = run_base + ACC_W'(sum);
        wcnt_d = wcnt_base + WCNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q  <= '0;
      v1_q   <= 1'b0;
      out_q  <= '0;
      dec_q  <= '0;
      vout_q <= 1'b0;
      run_q  <= '0;
      wcnt_q <= '0;
      acc_q  <= '0;
      accv_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      v1_q   <= v1_d;
      out_q  <= out_d;
      dec_q  <= dec_d;
      vout_q <= vout_d;
      run_q  <= run_d;
      wcnt_q <= wcnt_d;
      acc_q  <= acc_d;
      accv_q <= accv_d;
    end
  end

  assign Output    = out_q;
  assign Decision  = dec_q;
  assign Valid_out = vout_q;
  assign Acc       = acc_q;
  assign Acc_valid = accv_q;

endmodule

// File: tb/tb_sumatoria_acumulada.sv
// Bench for sumatoria_acumulada: directed scenarios plus random traffic,
// checked every cycle against a queue-based period model.
module tb_sumatoria_acumulada;
  import sumatoria_pkg::*;

  localparam int SAMPLES = 2;
  localparam int OSF     = 8;
  localparam int WORDS   = 4;
  localparam int W       = SAMPLES * OSF;
  localparam int SUM_W   = sum_w(SAMPLES, OSF);
  localparam int ACC_W   = acc_w(SAMPLES, OSF, WORDS);

  logic               Clk = 1'b0;
  logic               Rst, Enable, Valid_in, Clear;
  logic [W-1:0]       Input;
  logic [SUM_W-1:0]   Output;
  logic [SAMPLES-1:0] Decision;
  logic               Valid_out;
  logic [ACC_W-1:0]   Acc;
  logic               Acc_valid;

  sumatoria_acumulada #(.SAMPLES(SAMPLES), .OSF(OSF), .WORDS(WORDS)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Valid_in(Valid_in), .Input(Input),
    .Clear(Clear), .Output(Output), .Decision(Decision), .Valid_out(Valid_out),
    .Acc(Acc), .Acc_valid(Acc_valid)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Model state: the word waiting one cycle, the expected outputs, and the
  // list of word totals collected so far in the current period.
  bit                 s1v;
  logic [W-1:0]       s1w;
  int                 m_out, m_acc;
  logic [SAMPLES-1:0] m_dec;
  bit                 m_vout, m_accv;
  int                 per[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit en, input bit vi, input logic [W-1:0] w, input bit c);
    int tot;
    if (r) begin
      s1v = 0; m_out = 0; m_dec = '0; m_vout = 0; m_acc = 0; m_accv = 0;
      per.delete();
    end else begin
      m_vout = 0;
      m_accv = 0;
      if (c) per.delete();
      if (s1v) begin
        m_out  = $countones(s1w);
        for (int k = 0; k < SAMPLES; k++)
          m_dec[k] = ($countones((s1w >> (k*OSF)) & ((1 << OSF) - 1)) > OSF/2);
        m_vout = 1;
        per.push_back(m_out);
        if (per.size() == WORDS) begin
          tot = 0;
          foreach (per[i]) tot += per[i];
          m_acc  = tot;
          m_accv = 1;
          per.delete();
        end
      end
      s1v = en && vi;
      s1w = w;
    end
  endtask

  task automatic cyc(input bit r, input bit en, input bit vi, input logic [W-1:0] w, input bit c);
    Rst = r; Enable = en; Valid_in = vi; Input = w; Clear = c;
    @(posedge Clk);
    model(r, en, vi, w, c);
    @(negedge Clk);
  endtask

  task automatic word(input logic [W-1:0] w);
    cyc(0, 1, 1, w, 0);
  endtask

  task automatic idle();
    cyc(0, 1, 0, '0, 0);
  endtask

  // Checks a literal expectation against both the DUT and the model.
  task automatic lit(input string nm, input logic [31:0] dut_v, input int mdl_v, input int exp);
    check(nm, dut_v, exp);
    check({nm, "_model"}, mdl_v, exp);
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check("Valid_out", Valid_out, m_vout);
      check("Output",    Output,    m_out);
      check("Decision",  Decision,  m_dec);
      check("Acc_valid", Acc_valid, m_accv);
      check("Acc",       Acc,       m_acc);
    end
  end

  initial begin
    Rst = 1; Enable = 0; Valid_in = 0; Input = '0; Clear = 0;
    @(negedge Clk);
    cyc(1, 0, 0, '0, 0);
    chk_en = 1;
    cyc(1, 1, 1, 16'hFFFF, 1);
    cyc(1, 0, 0, '0, 0);
    idle();
    lit("rst_vout", Valid_out, m_vout, 0);
    lit("rst_out",  Output,    m_out,  0);
    lit("rst_acc",  Acc,       m_acc,  0);

    // Single word latency
    word(16'h0001);
    lit("lat_vout_early", Valid_out, m_vout, 0);
    idle();
    lit("lat_vout", Valid_out, m_vout, 1);
    lit("lat_out",  Output,    m_out,  1);
    lit("lat_dec",  Decision,  m_dec,  0);
    idle();
    lit("lat_vout_after", Valid_out, m_vout, 0);

    // Decisions, including a tie
    word(16'h00FF);
    word(16'h001F); lit("d0_out", Output, m_out, 8); lit("d0_dec", Decision, m_dec, 1);
    word(16'h000F); lit("d1_out", Output, m_out, 5); lit("d1_dec", Decision, m_dec, 1);
    word(16'hFF10); lit("d2_out", Output, m_out, 4); lit("d2_dec", Decision, m_dec, 0);
    lit("d2_acc", Acc, m_acc, 18);
    idle();         lit("d3_out", Output, m_out, 9); lit("d3_dec", Decision, m_dec, 2);

    // Clear on an idle cycle, then a full back-to-back period
    cyc(0, 1, 0, '0, 1);
    word(16'h0001);
    word(16'h0003); lit("p1_accv0", Acc_valid, m_accv, 0);
    word(16'h0007); lit("p1_accv1", Acc_valid, m_accv, 0);
    word(16'h000F); lit("p1_accv2", Acc_valid, m_accv, 0);
    idle();         lit("p1_acc", Acc, m_acc, 10); lit("p1_accv3", Acc_valid, m_accv, 1);
    idle();         lit("p1_accv_drop", Acc_valid, m_accv, 0);

    // Bubbles and dropped words do not break the period
    word(16'hFFFF);
    cyc(0, 0, 1, 16'h1234, 0);
    idle();
    word(16'hFFFF);
    cyc(0, 0, 1, 16'hAAAA, 0);
    word(16'hFFFF);
    idle();
    word(16'hFFFF); lit("p2_accv_early", Acc_valid, m_accv, 0);
    idle();         lit("p2_acc", Acc, m_acc, 64); lit("p2_accv", Acc_valid, m_accv, 1);

    // Clear alongside the third word's stage 2
    word(16'h0003);
    word(16'h0003);
    word(16'h0003);
    cyc(0, 1, 1, 16'h0003, 1);
    word(16'h0003); lit("c_accv0", Acc_valid, m_accv, 0);
    word(16'h0003); lit("c_accv1", Acc_valid, m_accv, 0);
    idle();         lit("c_acc", Acc, m_acc, 8); lit("c_accv", Acc_valid, m_accv, 1);

    // Reset mid-period
    word(16'h0001);
    word(16'h0001);
    cyc(1, 1, 1, 16'h0001, 0);
    lit("mr_vout", Valid_out, m_vout, 0);
    lit("mr_out",  Output,    m_out,  0);
    lit("mr_acc",  Acc,       m_acc,  0);
    repeat (4) word(16'h0001);
    idle();         lit("mr_acc4", Acc, m_acc, 4); lit("mr_accv", Acc_valid, m_accv, 1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] w;
      case ($urandom_range(0, 3))
        0:       w = '1;
        1:       w = logic'($urandom_range(0, 1)) ? 16'h0F0F : 16'h00F0;
        default: w = W'($urandom);
      endcase
      cyc($urandom_range(0, 60) == 0, $urandom_range(0, 9) < 8,
          $urandom_range(0, 9) < 7, w, $urandom_range(0, 14) == 0);
    end
    idle();
    idle();

    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sumatoria_acumulada.md
# sumatoria_acumulada

Pipelined, parametrised successor to the combinational oversampled-bit summation block. Each valid input word carries SAMPLES slices of OSF oversampled bits. For every word the block produces three things: the per-slice majority decision, the total count of ones in the word, and a running total of that count over WORDS consecutive valid words. It sits between the oversampling front end and the bit-recovery/threshold logic, and replaces the unclocked summation stage there.

## Interface
- SAMPLES, 2, number of sample slices per input word
- OSF, 8, oversampling factor (bits per slice); must be ≥2 and even
- WORDS, 4, number of valid words summed per accumulation period; must be ≥1
- Derived: CNT_W = $clog2(OSF)+1, SUM_W = $clog2(SAMPLES*OSF)+1, ACC_W = $clog2(SAMPLES*OSF*WORDS)+1
- Clk  in  1  single clock, rising edge
- Rst  in  1  synchronous, active-high reset
- Enable  in  1  block enable; when low, Valid_in is ignored
- Valid_in  in  1  Input is presented this cycle
- Input  in  SAMPLES*OSF  oversampled word; slice k = Input[k*OSF +: OSF]
- Clear  in  1  synchronous restart of the accumulation period
- Output  out  SUM_W  number of ones in the word (registered)
- Decision  out  SAMPLES  bit k = 1 when the ones-count of slice k > OSF/2
- Valid_out  out  1  Output/Decision valid this cycle
- Acc  out  ACC_W  sum of Output over the last completed period
- Acc_valid  out  1  one-cycle pulse when Acc is updated

## Operation
- Stage 1: capture when Enable && Valid_in. Register the per-slice popcounts (SAMPLES × CNT_W) and v1.
- Stage 2: when v1 is set:
  - Output ← sum of the slice counts.
  - Decision[k] ← (cnt_k > OSF/2). A tie (cnt_k == OSF/2) gives 0.
  - Valid_out ← 1. When v1 is clear, Valid_out ← 0, and Output and Decision hold their last values.
- Accumulator: running sum run (ACC_W) and word counter wcnt (0..WORDS-1), both updated in stage 2 when v1 is set.
  - If wcnt == WORDS-1: Acc ← run + sum, Acc_valid ← 1, run ← 0, wcnt ← 0.
  - Otherwise: run ← run + sum, wcnt ← wcnt + 1, Acc_valid ← 0.
- WORDS == 1: every valid word produces Acc = Output with Acc_valid set.
- Clear (any cycle) abandons the partial period.
  - Clear with v1 set: the current word starts a new period. run ← sum, wcnt ← 1, no Acc_valid. If WORDS == 1, Acc ← sum and Acc_valid ← 1.
  - Clear with v1 clear: run ← 0, wcnt ← 0.
  - Clear does not affect Output, Decision or Valid_out, and does not touch words already in stage 1.
- Enable low: no new capture. Words already in flight still complete, and accumulator state is retained.
- Widths: the sums cannot overflow by construction. All arithmetic is unsigned and zero-extended to the destination width.

## Timing
- Latency: Input sampled at edge N gives Valid_out/Output/Decision after edge N+1 (two-register pipeline).
- Acc_valid coincides with the Valid_out of the WORDS-th valid word of a period.
- Throughput is one word per cycle. There is no backpressure. Gaps in Valid_in/Enable insert bubbles and do not break the period.
- Reset values: Output=0, Decision=0, Valid_out=0, Acc=0, Acc_valid=0, v1=0, run=0, wcnt=0.
- Rst dominates Clear, Enable and Valid_in. Reset mid-period discards the in-flight words and the partial sum. The first valid word after Rst deasserts starts a fresh period.

## Structure
- Shared package sumatoria_pkg holds:
  - the width functions: cnt_w(osf), sum_w(samples, osf), acc_w(samples, osf, words);
  - the majority-threshold constant helper.
- One sub-module, popcount_slice: parametrised on OSF, combinational, OSF bits in, CNT_W bits out. It is instantiated SAMPLES times in stage 1.
- The accumulator and word counter are inline; no FSM is needed beyond wcnt.

## Test plan (SAMPLES=2, OSF=8, WORDS=4)
- Rst held 3 cycles, then idle → all outputs 0, no Valid_out.
- Single valid word 16'h0001 at cycle N → Output=1, Decision=2'b00, Valid_out high exactly at cycle N+2.
- Words 16'h00FF, 16'h001F, 16'h000F, 16'hFF10 → Output 8, 5, 4, 9 and Decision 01, 01, 00 (tie), 10.
- Words 0x0001, 0x0003, 0x0007, 0x000F back-to-back → Acc=10, Acc_valid on the 4th Valid_out only. Then 4× 16'hFFFF with bubbles and Enable dropped between words (dropped words ignored) → Acc=64.
- Tie/ownership checks:
  - Two valid words, then Clear coincident with the 3rd word's stage 2, then 3 more words (all 0x0003) → Acc=8 after the 6th word.
  - Clear on an idle cycle → run and wcnt zeroed.
- Rst asserted after 2 valid words of a period → outputs 0 next cycle. 4 subsequent 0x0001 words → Acc=4.
